keypad_scan: RTL and testbench
==============================

KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL have parameter SCAN_TICKS, default 250000: clk cycles each column is driven before its rows are sampled (min 4).
REQ-002 SHALL have parameter DEBOUNCE_SCANS, default 4: consecutive identical full scans needed to accept a press or a release (min 1).
REQ-003 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port row_n  input  4  keypad rows, externally pulled up, low = key closed on the driven column.
REQ-006 SHALL have port col_n  output  4  keypad column drive, exactly one bit low at any time outside reset.
REQ-007 SHALL have port key_code  output  4  code of the accepted key, row*4+col.
REQ-008 SHALL have port key_valid  output  1  one-cycle pulse when a press is accepted.
REQ-009 SHALL have port key_down  output  1  high while an accepted key is held.

Function
REQ-010 SHALL pass row_n through a two-flop synchronizer before any use.
REQ-011 SHALL keep a dwell counter 0..SCAN_TICKS-1; at SCAN_TICKS-1 it samples the synchronized rows for the current column, wraps to 0 and advances the column 0->1->2->3->0.
REQ-012 SHALL drive col_n = ~(4'b0001 << col) combinationally from the column register.
REQ-013 SHALL build a scan result over one full scan (columns 0..3): the first closed switch in ascending (col, row) order wins, so simultaneous keys resolve to the lowest col, then lowest row.
REQ-014 SHALL evaluate the FSM only at the end of column 3's dwell (scan end); the FSM holds between scan ends.
REQ-015 SHALL implement FSM IDLE, DEBOUNCE, PRESSED, RELEASE with a debounce counter and a candidate code register.
REQ-016 IDLE: a key in the scan result -> DEBOUNCE, candidate = code, count = 1 (if DEBOUNCE_SCANS = 1, go directly to PRESSED with acceptance).
REQ-017 DEBOUNCE: same code -> count+1, and on reaching DEBOUNCE_SCANS -> PRESSED; different code -> restart with the new candidate, count = 1; no key -> IDLE.
REQ-018 On entry to PRESSED SHALL load key_code = candidate, pulse key_valid for exactly one cycle, and set key_down = 1.
REQ-019 PRESSED: no key in the scan -> RELEASE, count = 1; any key -> stay, with no further key_valid pulses and key_code unchanged.
REQ-020 RELEASE: no key -> count+1, and on reaching DEBOUNCE_SCANS -> IDLE with key_down = 0; any key -> PRESSED without a key_valid pulse.
REQ-021 key_code SHALL hold its last accepted value after release.

Reset
REQ-022 Reset asserted SHALL asynchronously force: column = 0 (col_n = 4'b1110), counters = 0, synchronizer = 4'hF, FSM = IDLE, key_code = 0, key_valid = 0, key_down = 0.
REQ-023 Reset asserted mid-debounce or mid-press SHALL discard all pending state; after release, scanning restarts at column 0 with no key_valid pulse.

Configuration
REQ-024 With KEYPAD_SHIFT_EN defined, the block SHALL add outputs key_buf (32 bits) and key_buf_valid (8 bits). On each key_valid, key_buf <= {key_buf[27:0], key_code} and key_buf_valid <= {key_buf_valid[6:0], 1'b1}. Both reset to 0. These outputs feed the 8-digit display mask inputs directly.
REQ-025 Without KEYPAD_SHIFT_EN, these ports and registers SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-026 SHALL place the FSM state encoding, the column count (4) and the row count (4) in the shared project package.
REQ-027 SHALL instantiate one sub-module, sync2, a parameterized-width two-flop synchronizer, for row_n.

Verification (SCAN_TICKS=4, DEBOUNCE_SCANS=2, full scan = 16 cycles)
REQ-028 Idle, no keys after reset -> col_n cycles 1110, 1101, 1011, 0111, each for 4 cycles; key_valid never asserts.
REQ-029 Hold row 1 on column 2 steadily -> exactly one key_valid pulse, key_code = 6, and key_down = 1 by the end of the second full scan; key_down falls 2 scans after release.
REQ-030 Key bouncing, present in alternate scans -> no key_valid; FSM alternates IDLE and DEBOUNCE.
REQ-031 Simultaneous keys (row 3, col 1) and (row 0, col 2) -> key_code = 13 (lowest column wins), with a single pulse.
REQ-032 Reset asserted in DEBOUNCE -> outputs return to reset values immediately, with no pulse afterwards unless the key is re-debounced.
REQ-033 With KEYPAD_SHIFT_EN, press keys 1, 2, 3 -> key_buf = 32'h0000_0123 and key_buf_valid = 8'b0000_0111.

Source files
------------

// File: rtl/keypad_scan_pkg.sv
// Shared definitions for the 4x4 keypad scanner: matrix geometry and FSM encoding.
package keypad_scan_pkg;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } kp_state_t;

  // Key code layout is row*4+col, i.e. {row, col}.
  function automatic logic [3:0] key_index(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/sync2.sv
// Parameterized-width two-flop synchronizer with a configurable reset value.
module sync2 #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with per-scan debounce FSM.
// Optional KEYPAD_SHIFT_EN adds an 8-digit shift buffer of accepted key codes.
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int SCAN_TICKS     = 250000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_ROWS-1:0] row_n,
  output logic [NUM_COLS-1:0] col_n,
  output logic [3:0]          key_code,
  output logic                key_valid,
  output logic                key_down,
  output kp_state_t           fsm_state
`ifdef KEYPAD_SHIFT_EN
  ,
  output logic [31:0]         key_buf,
  output logic [7:0]          key_buf_valid
`endif
);

  localparam int              TW         = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam logic [TW-1:0]   TICK_LAST  = TW'(SCAN_TICKS - 1);
  localparam int              CW         = (DEBOUNCE_SCANS > 0) ? $clog2(DEBOUNCE_SCANS + 1) : 1;
  localparam logic [CW-1:0]   DEB_TARGET = CW'(DEBOUNCE_SCANS);

  logic [NUM_ROWS-1:0] row_sync;
  logic [NUM_ROWS-1:0] row_closed;
  logic [TW-1:0]       tick;
  logic [1:0]          col;
  logic                col_done;
  logic                scan_end;
  logic                col_hit;
  logic [1:0]          col_row;
  logic                acc_found;
  logic [3:0]          acc_code;
  logic                scan_hit;
  logic [3:0]          scan_code;

  kp_state_t           state, state_next;
  logic [CW-1:0]       cnt, cnt_next, cnt_inc;
  logic [3:0]          cand, cand_next;
  logic                accept;

  sync2 #(.WIDTH(NUM_ROWS), .RESET_VAL('1)) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d   (row_n),
    .q   (row_sync)
  );

  assign col_n    = ~(4'b0001 << col);
  assign col_done = (tick == TICK_LAST);
  assign scan_end = col_done && (col == 2'd3);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick <= '0;
      col  <= '0;
    end else if (col_done) begin
      tick <= '0;
      col  <= col + 2'd1;
    end else begin
      tick <= tick + TW'(1);
    end
  end

  // Lowest closed row on the driven column; rows are active-low.
  assign row_closed = ~row_sync;
  assign col_hit    = |row_closed;

  always_comb begin
    col_row = '0;
    for (int r = NUM_ROWS - 1; r >= 0; r--) begin
      if (row_closed[r]) col_row = 2'(r);
    end
  end

  // Earlier columns win, so the accumulator only latches the first hit of a scan.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_found <= 1'b0;
      acc_code  <= '0;
    end else if (col_done) begin
      if (col == 2'd3) begin
        acc_found <= 1'b0;
        acc_code  <= '0;
      end else if (!acc_found && col_hit) begin
        acc_found <= 1'b1;
        acc_code  <= key_index(col_row, col);
      end
    end
  end

  assign scan_hit  = acc_found || col_hit;
  assign scan_code = acc_found ? acc_code : key_index(col_row, col);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      cand  <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      cand  <= cand_next;
    end
  end

  assign cnt_inc = cnt + CW'(1);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    cand_next  = cand;
    accept     = 1'b0;
    if (scan_end) begin
      case (state)
        ST_IDLE: begin
          if (scan_hit) begin
            cand_next = scan_code;
            if (DEB_TARGET == CW'(1)) begin
              state_next = ST_PRESSED;
              accept     = 1'b1;
            end else begin
              state_next = ST_DEBOUNCE;
              cnt_next   = CW'(1);
            end
          end
        end
        ST_DEBOUNCE: begin
          if (!scan_hit) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
          end else if (scan_code != cand) begin
            cand_next = scan_code;
            cnt_next  = CW'(1);
          end else if (cnt_inc == DEB_TARGET) begin
            state_next = ST_PRESSED;
            cnt_next   = '0;
            accept     = 1'b1;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        ST_PRESSED: begin
          if (!scan_hit) begin
            if (DEB_TARGET == CW'(1)) begin
              state_next = ST_IDLE;
              cnt_next   = '0;
            end else begin
              state_next = ST_RELEASE;
              cnt_next   = CW'(1);
            end
          end
        end
        ST_RELEASE: begin
          if (scan_hit) begin
            state_next = ST_PRESSED;
            cnt_next   = '0;
          end else if (cnt_inc == DEB_TARGET) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        default: begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_comb begin
    key_down  = (state == ST_PRESSED) || (state == ST_RELEASE);
    fsm_state = state;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_valid <= 1'b0;
      key_code  <= '0;
    end else begin
      key_valid <= accept;
      if (accept) key_code <= cand_next;
    end
  end

`ifdef KEYPAD_SHIFT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_buf       <= '0;
      key_buf_valid <= '0;
    end else if (key_valid) begin
      key_buf       <= {key_buf[27:0], key_code};
      key_buf_valid <= {key_buf_valid[6:0], 1'b1};
    end
  end
`endif

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a keypad matrix model drives row_n from col_n, and a
// scan-level reference (run lengths of identical scan results) predicts the outputs.
module tb_keypad_scan;
  import keypad_scan_pkg::*;

  localparam int ST       = 4;
  localparam int DB       = 2;
  localparam int SCAN_CYC = 4 * ST;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;
  kp_state_t  fsm_state;
`ifdef KEYPAD_SHIFT_EN
  logic [31:0] key_buf;
  logic [7:0]  key_buf_valid;
  logic [31:0] exp_buf  = '0;
  logic [7:0]  exp_bufv = '0;
`endif

  logic [15:0] keys = '0;
  int          checks = 0;
  int          failures = 0;

  // Reference model state
  int          key_run = 0;
  int          none_run = 0;
  int          last_code = -1;
  bit          down = 1'b0;
  logic [3:0]  exp_code = '0;
  int          exp_pulses = 0;
  int          seen_pulses = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  keypad_scan #(.SCAN_TICKS(ST), .DEBOUNCE_SCANS(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down),
    .fsm_state (fsm_state)
`ifdef KEYPAD_SHIFT_EN
    ,
    .key_buf       (key_buf),
    .key_buf_valid (key_buf_valid)
`endif
  );

  // Keypad matrix: bit r*4+c closed pulls row r low while column c is driven.
  always_comb begin
    row_n = 4'hF;
    for (int c = 0; c < 4; c++) begin
      if (!col_n[c]) begin
        for (int r = 0; r < 4; r++) begin
          if (keys[r*4+c]) row_n[r] = 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every key_valid pulse consumes one predicted code.
  always @(negedge clk) begin
    if (rst && key_valid) begin
      seen_pulses++;
      if (exp_q.size() > 0) check("pulse_code", 32'(key_code), exp_q.pop_front());
    end
  end

  function automatic void scan_result(input logic [15:0] m, output bit hit, output int code);
    hit  = 1'b0;
    code = -1;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (!hit && m[r*4+c]) begin
          hit  = 1'b1;
          code = r * 4 + c;
        end
      end
    end
  endfunction

  function automatic kp_state_t exp_state();
    if (!down) return (key_run > 0) ? ST_DEBOUNCE : ST_IDLE;
    return (none_run > 0) ? ST_RELEASE : ST_PRESSED;
  endfunction

  task automatic model_reset();
    key_run   = 0;
    none_run  = 0;
    last_code = -1;
    down      = 1'b0;
    exp_code  = '0;
    exp_q.delete();
`ifdef KEYPAD_SHIFT_EN
    exp_buf  = '0;
    exp_bufv = '0;
`endif
  endtask

  // Hold key mask m for one full scan, then compare outputs with the reference.
  task automatic apply_scan(input logic [15:0] m, input bit check_cols);
    bit         hit;
    int         code;
    bit         accept;
    logic [3:0] ec;
    keys = m;
    for (int k = 1; k <= SCAN_CYC; k++) begin
      @(posedge clk);
      #1;
      if (check_cols) begin
        ec = ~(4'b0001 << ((k / ST) % 4));
        check("col_n", 32'(col_n), 32'(ec));
      end
    end
`ifdef KEYPAD_SHIFT_EN
    check("key_buf", key_buf, exp_buf);
    check("key_buf_valid", 32'(key_buf_valid), 32'(exp_bufv));
`endif
    scan_result(m, hit, code);
    accept = 1'b0;
    if (hit) begin
      none_run  = 0;
      key_run   = (code == last_code && key_run > 0) ? key_run + 1 : 1;
      last_code = code;
    end else begin
      key_run   = 0;
      last_code = -1;
      none_run++;
    end
    if (!down && hit && key_run >= DB) begin
      down     = 1'b1;
      accept   = 1'b1;
      exp_code = 4'(code);
      exp_pulses++;
      exp_q.push_back(32'(code));
`ifdef KEYPAD_SHIFT_EN
      exp_buf  = {exp_buf[27:0], exp_code};
      exp_bufv = {exp_bufv[6:0], 1'b1};
`endif
    end else if (down && none_run >= DB) begin
      down = 1'b0;
    end
    check("key_valid", 32'(key_valid), 32'(accept));
    check("key_down", 32'(key_down), 32'(down));
    check("key_code", 32'(key_code), 32'(exp_code));
    check("fsm_state", 32'(fsm_state), 32'(exp_state()));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_col_n"}, 32'(col_n), 32'h0000_000E);
    check({tag, "_key_valid"}, 32'(key_valid), 32'd0);
    check({tag, "_key_down"}, 32'(key_down), 32'd0);
    check({tag, "_key_code"}, 32'(key_code), 32'd0);
    check({tag, "_state"}, 32'(fsm_state), 32'(ST_IDLE));
`ifdef KEYPAD_SHIFT_EN
    check({tag, "_key_buf"}, key_buf, 32'd0);
`endif
  endtask

  initial begin
    logic [15:0] m;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b1;

    // Idle scanning with column sequence checks
    apply_scan(16'h0000, 1'b1);
    apply_scan(16'h0000, 1'b1);

    // Row 1 / column 2 held steadily, then released
    repeat (3) apply_scan(16'h0040, 1'b0);
    repeat (3) apply_scan(16'h0000, 1'b0);

    // Bouncing key present in alternate scans
    for (int i = 0; i < 6; i++) apply_scan((i % 2 == 0) ? 16'h0200 : 16'h0000, 1'b0);

    // Simultaneous (row3,col1) and (row0,col2)
    repeat (3) apply_scan(16'h2004, 1'b0);
    repeat (3) apply_scan(16'h0000, 1'b0);

    // Keys 1, 2, 3 in sequence
    for (int k = 1; k <= 3; k++) begin
      m = 16'h0001 << k;
      repeat (2) apply_scan(m, 1'b0);
      repeat (2) apply_scan(16'h0000, 1'b0);
    end

    // Randomized key patterns, held or changed per scan
    m = '0;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        m = '0;
        for (int j = 0; j < int'($urandom_range(0, 2)); j++) m[$urandom_range(0, 15)] = 1'b1;
      end
      apply_scan(m, 1'b0);
    end

    // Force a key accepted so key_code is non-zero, then reset mid-debounce
    repeat (2) apply_scan(16'h0000, 1'b0);
    repeat (2) apply_scan(16'h0800, 1'b0);
    repeat (2) apply_scan(16'h0000, 1'b0);
    apply_scan(16'h0020, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_reset_values("async_reset");
    keys = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    apply_scan(16'h0000, 1'b1);
    repeat (2) apply_scan(16'h0000, 1'b0);
    repeat (3) apply_scan(16'h0020, 1'b0);
    repeat (3) apply_scan(16'h0000, 1'b0);

    repeat (4) @(posedge clk);
    check("pulse_count", 32'(seen_pulses), 32'(exp_pulses));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
